html_stream_parser: RTL and testbench
=====================================

Name: html_stream_parser

Overview:
- Parametrised successor to the single-font HTML state holder.
- Consumes a byte stream of simplified HTML.
- Tracks nested text style (color, size) on a bounded stack and lays out text with line wrap.
- Emits one draw command per glyph or block to the renderer through a valid/ready handshake. It sits between the page-fetch byte source and the frame-buffer drawer.

Parameters:
X_W, 10, x coordinate width
Y_W, 9, y coordinate width
COLOR_W, 8, color width
VAL_W, 8, attribute value width (decimal values saturate at 2^VAL_W-1)
STACK_DEPTH, 4, max nested <font> levels
SCREEN_W, 640, wrap limit in pixels
GLYPH_W, 8, base glyph width (scaled by size)
GLYPH_H, 8, base glyph height (scaled by size)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
char  in  8  ASCII input byte
char_valid  in  1  char present
char_ready  out  1  byte accepted when char_valid&&char_ready
cmd_valid  out  1  draw command present
cmd_ready  in  1  renderer accepts
cmd_kind  out  1  0=glyph, 1=block
cmd_char  out  8  glyph code (0 for block)
cmd_x  out  X_W  command x
cmd_y  out  Y_W  command y
cmd_color  out  COLOR_W  text or block color
cmd_w  out  X_W  glyph: GLYPH_W*size; block: w attribute
cmd_h  out  Y_W  glyph: GLYPH_H*size; block: h attribute
overflow  out  1  sticky: push on full stack or pop on empty stack

Behaviour:
- Reset (async):
  - All outputs 0 except char_ready=1.
  - Text state: color=0, size=1, x=0, y=0.
  - Stack empty; FSM in TEXT.
- Handshake:
  - One output register. char_ready = !cmd_valid || cmd_ready.
  - A consumed byte that produces a command sets cmd_valid on the next edge.
  - cmd fields hold stable while cmd_valid && !cmd_ready.
  - Throughput is 1 byte/cycle when the renderer is always ready.
- FSM states: TEXT, TAG_START, TAG_NAME, ATTR_WAIT, ATTR_NAME, ATTR_EQ, ATTR_VAL.
  - TEXT: '<' -> TAG_START. '\n' or '\r' is ignored. Any other byte is a printable glyph:
    - If x + GLYPH_W*size > SCREEN_W: wrap first (x=0, y += GLYPH_H*size).
    - Emit glyph at the post-wrap x,y, then x += GLYPH_W*size.
    - Size 0 is treated as 1.
  - TAG_START: '/' sets close flag and stays. First name byte latches tag id: 'f'=FONT, 'd'=DIV, 'b'=BR, other=UNKNOWN. Then -> TAG_NAME.
  - TAG_NAME: further letters are ignored. Space -> ATTR_WAIT. '>' -> tag end.
  - ATTR_WAIT: space stays. '>' -> tag end. Letter latches attr id ('c'=color, 's'=size, 'w'=width, 'h'=height, other=ignore) -> ATTR_NAME.
  - ATTR_NAME: letters ignored. '=' -> ATTR_EQ. Space -> ATTR_WAIT. '>' -> tag end.
  - ATTR_EQ / ATTR_VAL:
    - '"' is ignored.
    - A digit sets val = val*10+d, saturating at VAL_W max, and the state goes to ATTR_VAL.
    - Space or closing quote commits val to the pending attribute register -> ATTR_WAIT.
    - '>' commits val, then tag end.
    - A non-digit other than these aborts the value (no commit) -> ATTR_WAIT.
  - Pending attribute registers clear at TAG_START. Defaults: color=current, size=current, w=0, h=0.
- Tag end (on the '>' byte, then -> TEXT):
  - open FONT:
    - Push {color,size} if depth<STACK_DEPTH, else set overflow and do not push.
    - Apply pending color/size regardless of the push outcome.
  - close FONT: pop and restore if depth>0, else set overflow and keep state.
  - BR (open or close): x=0, y += GLYPH_H*size.
  - open DIV:
    - If x != 0, move to a new line first.
    - Emit block at (0,y) with pending w, h and color.
    - Then y += h, x=0.
    - w truncates to X_W; a block with w=0 or h=0 is still emitted.
  - close DIV and UNKNOWN tags: no effect.
- Arithmetic:
  - x, y wrap modulo 2^X_W / 2^Y_W; no vertical clip.
  - size multiply result is truncated to X_W / Y_W.
- overflow clears only on reset.
- Reset mid-tag or mid-handshake: the pending command is dropped and the FSM returns to TEXT.

Test Plan:
- Bytes "Hi" with cmd_ready=1 -> 2 glyph commands: ('H',0,0,w8,h8), ('i',8,0).
- "<font color=12 size=2>A</font>B" -> A: color 12, w16 at x0. B: color 0, w8 at x16.
- 81 'a' bytes with size 1, SCREEN_W=640 -> 81st glyph at (0,8).
- Five nested <font size=N> with STACK_DEPTH=4, then five </font> -> overflow=1. After the pops, size equals the value before the 1st font; extra pop holds.
- "x<div w=100 h=20 color=3>y" -> glyph x at (0,0). Block (0,8,w100,h20,color3). Glyph y at (0,28).
- cmd_ready held 0 for 5 cycles mid-stream -> char_ready=0; cmd fields stable; no byte lost; "size=999" saturates to 255.

Source files
------------

// File: rtl/html_stream_parser.sv
// Streaming parser for a small subset of HTML: plain text, <font color size>,
// <div w h color>, <br>. It keeps a bounded style stack, lays glyphs out with
// line wrap and hands one draw command per glyph or block to the renderer.
module html_stream_parser #(
    parameter int X_W         = 10,
    parameter int Y_W         = 9,
    parameter int COLOR_W     = 8,
    parameter int VAL_W       = 8,
    parameter int STACK_DEPTH = 4,
    parameter int SCREEN_W    = 640,
    parameter int GLYPH_W     = 8,
    parameter int GLYPH_H     = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [7:0]         char,
    input  logic               char_valid,
    output logic               char_ready,
    output logic               cmd_valid,
    input  logic               cmd_ready,
    output logic               cmd_kind,
    output logic [7:0]         cmd_char,
    output logic [X_W-1:0]     cmd_x,
    output logic [Y_W-1:0]     cmd_y,
    output logic [COLOR_W-1:0] cmd_color,
    output logic [X_W-1:0]     cmd_w,
    output logic [Y_W-1:0]     cmd_h,
    output logic               overflow
);

    localparam int DEP_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [DEP_W-1:0] DEPTH_MAX = DEP_W'(STACK_DEPTH);

    localparam logic [7:0] C_LT = 8'h3C;
    localparam logic [7:0] C_GT = 8'h3E;
    localparam logic [7:0] C_SL = 8'h2F;
    localparam logic [7:0] C_SP = 8'h20;
    localparam logic [7:0] C_EQ = 8'h3D;
    localparam logic [7:0] C_QT = 8'h22;
    localparam logic [7:0] C_LF = 8'h0A;
    localparam logic [7:0] C_CR = 8'h0D;

    typedef enum logic [2:0] {
        TEXT, TAG_START, TAG_NAME, ATTR_WAIT, ATTR_NAME, ATTR_EQ, ATTR_VAL
    } state_t;

    typedef enum logic [1:0] {T_UNK, T_FONT, T_DIV, T_BR} tag_t;
    typedef enum logic [2:0] {A_NONE, A_COLOR, A_SIZE, A_W, A_H} attr_t;

    // Size 0 behaves like size 1 for all layout math.
    function automatic logic [VAL_W-1:0] eff_sz(input logic [VAL_W-1:0] s);
        return (s == '0) ? VAL_W'(1) : s;
    endfunction

    function automatic logic [X_W-1:0] glyph_w(input logic [VAL_W-1:0] s);
        logic [31:0] p;
        p = 32'(GLYPH_W) * 32'(eff_sz(s));
        return p[X_W-1:0];
    endfunction

    function automatic logic [Y_W-1:0] glyph_h(input logic [VAL_W-1:0] s);
        logic [31:0] p;
        p = 32'(GLYPH_H) * 32'(eff_sz(s));
        return p[Y_W-1:0];
    endfunction

    // Decimal accumulate, clamped to the all-ones value of VAL_W.
    function automatic logic [VAL_W-1:0] sat_accum(input logic [VAL_W-1:0] v,
                                                   input logic [7:0] c);
        logic [31:0] t;
        t = 32'(v) * 32'd10 + 32'(c - 8'h30);
        if (t > 32'({VAL_W{1'b1}}))
            return {VAL_W{1'b1}};
        return t[VAL_W-1:0];
    endfunction

    state_t             state;
    tag_t               tag_id;
    attr_t              attr_id;
    logic               close_flag;
    logic [VAL_W-1:0]   val;
    logic [COLOR_W-1:0] pend_color, eff_color;
    logic [VAL_W-1:0]   pend_size, eff_size;
    logic [VAL_W-1:0]   pend_w, eff_w;
    logic [VAL_W-1:0]   pend_h, eff_h;
    logic [COLOR_W-1:0] color;
    logic [VAL_W-1:0]   size;
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [DEP_W-1:0]   depth;
    logic [COLOR_W-1:0] stk_color [STACK_DEPTH];
    logic [VAL_W-1:0]   stk_size  [STACK_DEPTH];

    logic               accept, tag_end, commit, push_en;
    logic               is_digit, is_letter, wrap;
    logic [7:0]         lc;
    logic [X_W-1:0]     gw, gx;
    logic [Y_W-1:0]     gh, gy, div_y;
    logic [IDX_W-1:0]   push_idx, pop_idx;

    assign char_ready = !cmd_valid || cmd_ready;
    assign accept     = char_valid && char_ready;
    assign lc         = char | 8'h20;
    assign is_digit   = (char >= 8'h30) && (char <= 8'h39);
    assign is_letter  = (lc >= 8'h61) && (lc <= 8'h7A);
    assign tag_end    = accept && (state != TEXT) && (char == C_GT);
    assign commit     = accept && ((state == ATTR_EQ) || (state == ATTR_VAL)) &&
                        ((char == C_SP) || (char == C_GT) ||
                         ((char == C_QT) && (state == ATTR_VAL)));
    assign push_en    = tag_end && (tag_id == T_FONT) && !close_flag && (depth < DEPTH_MAX);

    assign gw       = glyph_w(size);
    assign gh       = glyph_h(size);
    assign wrap     = (32'(x) + 32'(gw)) > 32'(SCREEN_W);
    assign gx       = wrap ? '0 : x;
    assign gy       = wrap ? (y + gh) : y;
    assign div_y    = (x != '0) ? (y + gh) : y;
    assign push_idx = IDX_W'(depth);
    assign pop_idx  = IDX_W'(depth - 1'b1);

    // Pending attributes as they stand after this byte's value commit, so a
    // value terminated by '>' is visible to the tag-end action in the same cycle.
    always_comb begin
        eff_color = pend_color;
        eff_size  = pend_size;
        eff_w     = pend_w;
        eff_h     = pend_h;
        if (commit) begin
            case (attr_id)
                A_COLOR: eff_color = COLOR_W'(val);
                A_SIZE:  eff_size  = val;
                A_W:     eff_w     = val;
                A_H:     eff_h     = val;
                default: ;
            endcase
        end
    end

    // Style stack storage; only the depth counter needs reset.
    always_ff @(posedge clock) begin
        if (push_en) begin
            stk_color[push_idx] <= color;
            stk_size[push_idx]  <= size;
        end
    end

    // Parser FSM, text/layout state and the single output command register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= TEXT;
            tag_id     <= T_UNK;
            attr_id    <= A_NONE;
            close_flag <= 1'b0;
            val        <= '0;
            pend_color <= '0;
            pend_size  <= VAL_W'(1);
            pend_w     <= '0;
            pend_h     <= '0;
            color      <= '0;
            size       <= VAL_W'(1);
            x          <= '0;
            y          <= '0;
            depth      <= '0;
            overflow   <= 1'b0;
            cmd_valid  <= 1'b0;
            cmd_kind   <= 1'b0;
            cmd_char   <= '0;
            cmd_x      <= '0;
            cmd_y      <= '0;
            cmd_color  <= '0;
            cmd_w      <= '0;
            cmd_h      <= '0;
        end else begin
            if (cmd_valid && cmd_ready)
                cmd_valid <= 1'b0;
            if (accept) begin
                case (state)
                    TEXT: begin
                        if (char == C_LT) begin
                            state      <= TAG_START;
                            close_flag <= 1'b0;
                            tag_id     <= T_UNK;
                            attr_id    <= A_NONE;
                            pend_color <= color;
                            pend_size  <= size;
                            pend_w     <= '0;
                            pend_h     <= '0;
                        end else if (char != C_LF && char != C_CR) begin
                            cmd_valid <= 1'b1;
                            cmd_kind  <= 1'b0;
                            cmd_char  <= char;
                            cmd_x     <= gx;
                            cmd_y     <= gy;
                            cmd_color <= color;
                            cmd_w     <= gw;
                            cmd_h     <= gh;
                            x         <= gx + gw;
                            y         <= gy;
                        end
                    end
                    TAG_START: begin
                        if (char == C_SL) begin
                            close_flag <= 1'b1;
                        end else begin
                            case (lc)
                                8'h66:   tag_id <= T_FONT;
                                8'h64:   tag_id <= T_DIV;
                                8'h62:   tag_id <= T_BR;
                                default: tag_id <= T_UNK;
                            endcase
                            state <= TAG_NAME;
                        end
                    end
                    TAG_NAME: begin
                        if (char == C_SP)
                            state <= ATTR_WAIT;
                    end
                    ATTR_WAIT: begin
                        if (is_letter) begin
                            case (lc)
                                8'h63:   attr_id <= A_COLOR;
                                8'h73:   attr_id <= A_SIZE;
                                8'h77:   attr_id <= A_W;
                                8'h68:   attr_id <= A_H;
                                default: attr_id <= A_NONE;
                            endcase
                            val   <= '0;
                            state <= ATTR_NAME;
                        end
                    end
                    ATTR_NAME: begin
                        if (char == C_EQ) begin
                            val   <= '0;
                            state <= ATTR_EQ;
                        end else if (char == C_SP) begin
                            state <= ATTR_WAIT;
                        end
                    end
                    default: begin
                        // ATTR_EQ / ATTR_VAL: an opening quote is skipped, a
                        // quote after digits closes the value like a space.
                        if (char == C_QT) begin
                            if (state == ATTR_VAL)
                                state <= ATTR_WAIT;
                        end else if (is_digit) begin
                            val   <= sat_accum(val, char);
                            state <= ATTR_VAL;
                        end else begin
                            state <= ATTR_WAIT;
                        end
                    end
                endcase

                if (commit) begin
                    pend_color <= eff_color;
                    pend_size  <= eff_size;
                    pend_w     <= eff_w;
                    pend_h     <= eff_h;
                end

                if (tag_end) begin
                    state <= TEXT;
                    case (tag_id)
                        T_FONT: begin
                            if (!close_flag) begin
                                if (depth < DEPTH_MAX)
                                    depth <= depth + 1'b1;
                                else
                                    overflow <= 1'b1;
                                color <= eff_color;
                                size  <= eff_size;
                            end else if (depth != '0) begin
                                depth <= depth - 1'b1;
                                color <= stk_color[pop_idx];
                                size  <= stk_size[pop_idx];
                            end else begin
                                overflow <= 1'b1;
                            end
                        end
                        T_BR: begin
                            x <= '0;
                            y <= y + gh;
                        end
                        T_DIV: begin
                            if (!close_flag) begin
                                cmd_valid <= 1'b1;
                                cmd_kind  <= 1'b1;
                                cmd_char  <= '0;
                                cmd_x     <= '0;
                                cmd_y     <= div_y;
                                cmd_color <= eff_color;
                                cmd_w     <= X_W'(eff_w);
                                cmd_h     <= Y_W'(eff_h);
                                x         <= '0;
                                y         <= div_y + Y_W'(eff_h);
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_html_stream_parser.sv
// Bench for html_stream_parser: drives byte strings, queues the draw commands
// each string should produce and compares them as the renderer accepts them.
module tb_html_stream_parser;

    localparam int X_W     = 10;
    localparam int Y_W     = 9;
    localparam int COLOR_W = 8;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic [7:0]         char = '0;
    logic               char_valid = 1'b0;
    logic               char_ready;
    logic               cmd_valid;
    logic               cmd_ready = 1'b1;
    logic               cmd_kind;
    logic [7:0]         cmd_char;
    logic [X_W-1:0]     cmd_x;
    logic [Y_W-1:0]     cmd_y;
    logic [COLOR_W-1:0] cmd_color;
    logic [X_W-1:0]     cmd_w;
    logic [Y_W-1:0]     cmd_h;
    logic               overflow;

    html_stream_parser dut (
        .clock      (clock),
        .reset      (reset),
        .char       (char),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_kind   (cmd_kind),
        .cmd_char   (cmd_char),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .cmd_color  (cmd_color),
        .cmd_w      (cmd_w),
        .cmd_h      (cmd_h),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic               kind;
        logic [7:0]         ch;
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        logic [COLOR_W-1:0] color;
        logic [X_W-1:0]     w;
        logic [Y_W-1:0]     h;
    } cmd_t;

    cmd_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_cmds   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_cmd(input logic kind, input logic [7:0] ch, input int x, input int y,
                            input int color, input int w, input int h);
        cmd_t c;
        c.kind  = kind;
        c.ch    = ch;
        c.x     = X_W'(x);
        c.y     = Y_W'(y);
        c.color = COLOR_W'(color);
        c.w     = X_W'(w);
        c.h     = Y_W'(h);
        exp_q.push_back(c);
    endtask

    // Renderer side: compare on accepted handshakes, and require the
    // command to hold still while it is stalled.
    initial begin : monitor
        cmd_t cur, snap, e;
        logic held;
        held = 1'b0;
        snap = '0;
        forever begin
            @(negedge clock);
            cur = {cmd_kind, cmd_char, cmd_x, cmd_y, cmd_color, cmd_w, cmd_h};
            if (reset) begin
                held = 1'b0;
            end else begin
                if (cmd_valid && !cmd_ready) begin
                    if (held)
                        check_eq("hold_stable", 64'(cur), 64'(snap));
                    snap = cur;
                    held = 1'b1;
                end else begin
                    held = 1'b0;
                end
                if (cmd_valid && cmd_ready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("cmd_expected_count", 64'(exp_q.size()), 64'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq($sformatf("cmd%0d_kind", n_cmds),  64'(cur.kind),  64'(e.kind));
                        check_eq($sformatf("cmd%0d_char", n_cmds),  64'(cur.ch),    64'(e.ch));
                        check_eq($sformatf("cmd%0d_x", n_cmds),     64'(cur.x),     64'(e.x));
                        check_eq($sformatf("cmd%0d_y", n_cmds),     64'(cur.y),     64'(e.y));
                        check_eq($sformatf("cmd%0d_color", n_cmds), 64'(cur.color), 64'(e.color));
                        check_eq($sformatf("cmd%0d_w", n_cmds),     64'(cur.w),     64'(e.w));
                        check_eq($sformatf("cmd%0d_h", n_cmds),     64'(cur.h),     64'(e.h));
                    end
                    n_cmds++;
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        char       = b;
        char_valid = 1'b1;
        @(negedge clock);
        while (!char_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100)
            check_eq("char_ready_timeout", 64'(char_ready), 64'd1);
        @(posedge clock);
        #1;
        char_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++)
            send_byte(s[i]);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clock);
            n++;
        end
        check_eq(tag, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        char_valid = 1'b0;
        char       = '0;
        #1;
        reset = 1'b1;
        #1;
        check_eq("rst_cmd_valid",  64'(cmd_valid),  64'd0);
        check_eq("rst_char_ready", 64'(char_ready), 64'd1);
        check_eq("rst_overflow",   64'(overflow),   64'd0);
        check_eq("rst_cmd_fields", 64'({cmd_kind, cmd_char, cmd_x, cmd_y, cmd_color, cmd_w, cmd_h}), 64'd0);
        exp_q.delete();
        cmd_ready = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        do_reset();

        // Two plain glyphs at size 1.
        push_cmd(0, "H", 0, 0, 0, 8, 8);
        push_cmd(0, "i", 8, 0, 0, 8, 8);
        send_str("Hi");
        drain("drain_hi");

        // Font push/pop restores color and size.
        do_reset();
        push_cmd(0, "A", 0, 0, 12, 16, 16);
        push_cmd(0, "B", 16, 0, 0, 8, 8);
        send_str("<font color=12 size=2>A</font>B");
        drain("drain_font");

        // 80 glyphs fill 640 px exactly; the 81st wraps.
        do_reset();
        for (int i = 0; i < 80; i++)
            push_cmd(0, "a", 8 * i, 0, 0, 8, 8);
        push_cmd(0, "a", 0, 8, 0, 8, 8);
        for (int i = 0; i < 81; i++)
            send_byte("a");
        drain("drain_wrap");

        // Stack overflow on the 5th push and underflow on the 5th pop.
        do_reset();
        send_str("<font size=2><font size=3><font size=4><font size=5>");
        check_eq("ovf_after_4_push", 64'(overflow), 64'd0);
        send_str("<font size=6>");
        check_eq("ovf_after_5_push", 64'(overflow), 64'd1);
        push_cmd(0, "Y", 0, 0, 0, 48, 48);
        push_cmd(0, "X", 48, 0, 0, 8, 8);
        send_str("Y</font></font></font></font></font>X");
        check_eq("ovf_sticky", 64'(overflow), 64'd1);
        drain("drain_ovf");

        // Div moves to a new line, emits a block, then advances by h.
        do_reset();
        push_cmd(0, "x", 0, 0, 0, 8, 8);
        push_cmd(1, 8'h00, 0, 8, 3, 100, 20);
        push_cmd(0, "y", 0, 28, 0, 8, 8);
        send_str("x<div w=100 h=20 color=3>y");
        drain("drain_div");

        // Line break and a quoted attribute value.
        do_reset();
        push_cmd(0, "a", 0, 0, 0, 8, 8);
        push_cmd(0, "b", 0, 8, 7, 8, 8);
        send_str("a<br>");
        send_byte(8'h0A);
        send_str("<font color=");
        send_byte(8'h22);
        send_byte("7");
        send_byte(8'h22);
        send_str(">b</font>");
        drain("drain_br_quote");

        // Renderer stall, then size=999 saturating to 255:
        // w = 2040 mod 1024 = 1016, h = 2040 mod 512 = 504, x=16 forces a wrap.
        do_reset();
        push_cmd(0, "A", 0, 0, 0, 8, 8);
        push_cmd(0, "B", 8, 0, 0, 8, 8);
        push_cmd(0, "C", 0, 504, 0, 1016, 504);
        cmd_ready = 1'b0;
        fork
            send_str("AB<font size=999>C</font>");
            begin : release_blk
                int n;
                n = 0;
                while (!cmd_valid && n < 50) begin
                    @(negedge clock);
                    n++;
                end
                check_eq("stall_cmd_valid", 64'(cmd_valid), 64'd1);
                for (int i = 0; i < 5; i++) begin
                    @(negedge clock);
                    check_eq("stall_char_ready", 64'(char_ready), 64'd0);
                end
                @(posedge clock);
                #1;
                cmd_ready = 1'b1;
            end
        join
        drain("drain_stall");

        // Reset while a command is waiting drops it.
        do_reset();
        cmd_ready = 1'b0;
        send_byte("Q");
        @(negedge clock);
        check_eq("pending_before_reset", 64'(cmd_valid), 64'd1);
        do_reset();
        push_cmd(0, "R", 0, 0, 0, 8, 8);
        send_byte("R");
        drain("drain_after_reset");

        repeat (3) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
